// File: rtl/pipe_register_pkg.sv
// Shared slice state encoding and sizing helpers for pipe_register.

package pipe_register_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Each slice holds up to two words, so the pipeline holds 0..2*stages.
  function automatic int count_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One elastic slice: main + skid register, three-state FSM and a registered ready.
// The FSM state is an output so the parent can derive valid and observe occupancy.

module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output stage_state_e     state
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             ready_q;
  logic             fire_in;
  logic             fire_out;

  // Handshake: a word moves across a boundary on a rising edge where valid
  // and ready are both high (and the slice is enabled). Ready here is a flop,
  // so it never depends combinationally on the downstream ready.
  assign fire_in  = enable & in_valid & ready_q;
  assign fire_out = enable & (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (fire_in) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (fire_in && !fire_out) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (fire_out && !fire_in) begin
          state_d = ST_EMPTY;
        end else if (fire_in && fire_out) begin
          main_d = in_data;
        end
      end
      ST_TWO: begin
        if (fire_out) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Clearing drops ready for one cycle so acceptance resumes one edge later,
  // matching the behaviour after reset release.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else if (clear) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  assign in_ready = ready_q;
  assign out_data = main_q;
  assign state    = state_q;

endmodule

// File: rtl/pipe_register.sv
// Elastic pipeline register: STAGES skid slices under valid/ready with enable freeze
// and occupancy count. Optional flush port when PIPE_REGISTER_FLUSH_EN is defined.

module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic                             clk,
  input  logic                             rst_,
  input  logic                             enable,
`ifdef PIPE_REGISTER_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [count_width(STAGES)-1:0]   count
);

  localparam int            CW        = count_width(STAGES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(2 * STAGES);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $error("pipe_register: WIDTH and STAGES must both be >= 1");
  end

  logic flush_i;
`ifdef PIPE_REGISTER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Flush outranks enable: while it is high nothing may fire.
  logic run;
  assign run = enable & ~flush_i;

  logic [STAGES:0]  link_valid;
  logic [STAGES:0]  link_ready;
  logic [WIDTH-1:0] link_data [STAGES+1];
  stage_state_e     stage_state [STAGES];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign link_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_register_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_     (rst_),
      .enable   (run),
      .clear    (flush_i),
      .in_valid (link_valid[i]),
      .in_ready (link_ready[i]),
      .in_data  (link_data[i]),
      .out_ready(link_ready[i+1]),
      .out_data (link_data[i+1]),
      .state    (stage_state[i])
    );
    assign link_valid[i+1] = (stage_state[i] != ST_EMPTY);
  end

  assign in_ready  = run & link_ready[0];
  assign out_valid = run & link_valid[STAGES];
  assign out_data  = link_data[STAGES];

  logic            fire_in;
  logic            fire_out;
  logic [CW-1:0]   count_q;

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  // Guards keep the counter inside 0..2*STAGES even if the handshake misbehaves.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else if (fire_in && !fire_out && count_q != COUNT_MAX) begin
      count_q <= count_q + 1'b1;
    end else if (fire_out && !fire_in && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;

endmodule
